avl_stream_pixel_packer: RTL and testbench

- Parametrised successor to the fixed 8-bit RGB stream path between the PCIe/DMA side and the depth-estimation datapath.
- Accepts a byte-serial Avalon-ST stream and packs CHANNELS consecutive samples into one pixel beat.
- Frames the output with sop/eop from a programmable frame length, and exposes control/status through a small Avalon-MM register slave.
- Sits in the user clock domain between the Qsys stream source and the network input.

---
 rtl/avl_pixel_packer_pkg.sv | 26 ++
 rtl/pixel_packer_regs.sv | 86 ++++++++
 rtl/avl_stream_pixel_packer.sv | 188 ++++++++++++++++++
 tb/tb_avl_stream_pixel_packer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avl_pixel_packer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : avl_pixel_packer_pkg
// Brief    : Register map, CTRL bit positions and STATUS word layout shared by
//            the pixel packer and its register slave.
// Revision : 1.0 - initial release
// ============================================================================
package avl_pixel_packer_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_LEN    = 1;
    localparam int REG_STATUS = 2;
    localparam int REG_STALL  = 3;

    localparam int CTRL_ENABLE_BIT     = 0;
    localparam int CTRL_SOFT_CLEAR_BIT = 1;

    typedef struct packed {
        logic [15:0] frames_done;
        logic [13:0] reserved;
        logic        in_frame;
        logic        src_valid;
    } status_word_t;

endpackage
`default_nettype wire

// File: rtl/pixel_packer_regs.sv
`default_nettype none
// ============================================================================
// Module   : pixel_packer_regs
// Brief    : Avalon-MM control slave: CTRL / FRAME_LEN storage, soft_clear
//            strobe and fixed one-cycle read data.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_packer_regs
    import avl_pixel_packer_pkg::*;
#(
    parameter int LEN_W       = 20,
    parameter int DEFAULT_LEN = 307200,
    parameter int ADDR_W      = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_write,
    input  logic [31:0]       i_writedata,
    input  logic              i_read,
    output logic [31:0]       o_readdata,
    output logic              o_readdatavalid,
    input  status_word_t      i_status,
    input  logic [31:0]       i_stall_cnt,
    output logic              o_enable,
    output logic              o_soft_clear,
    output logic [LEN_W-1:0]  o_frame_len
);

    logic             r_enable;
    logic [LEN_W-1:0] r_frame_len;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;
    logic             w_wr_ctrl;
    logic             w_wr_len;
    logic [LEN_W-1:0] w_len_wdata;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr_ctrl   = i_write && (i_address == ADDR_W'(REG_CTRL));
    assign w_wr_len    = i_write && (i_address == ADDR_W'(REG_LEN));
    assign w_len_wdata = i_writedata[LEN_W-1:0];

    // soft_clear is a strobe on the write cycle itself; it never stores
    assign o_soft_clear = w_wr_ctrl && i_writedata[CTRL_SOFT_CLEAR_BIT];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable        <= 1'b0;
            r_frame_len     <= LEN_W'(DEFAULT_LEN);
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_enable <= i_writedata[CTRL_ENABLE_BIT];
            end
            if (w_wr_len) begin
                r_frame_len <= (w_len_wdata == '0) ? LEN_W'(1) : w_len_wdata;
            end
            r_readdatavalid <= i_read;
            if (i_read) begin
                r_readdata <= w_rdata;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (i_address)
            ADDR_W'(REG_CTRL):   w_rdata[CTRL_ENABLE_BIT] = r_enable;
            ADDR_W'(REG_LEN):    w_rdata = 32'(r_frame_len);
            ADDR_W'(REG_STATUS): w_rdata = i_status;
            ADDR_W'(REG_STALL):  w_rdata = i_stall_cnt;
            default:             w_rdata = '0;
        endcase
    end

    assign w_unused_wdata = ^i_writedata[31:LEN_W];

    assign o_readdata      = r_readdata;
    assign o_readdatavalid = r_readdatavalid;
    assign o_enable        = r_enable;
    assign o_frame_len     = r_frame_len;

endmodule
`default_nettype wire

// File: rtl/avl_stream_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : avl_stream_pixel_packer
// Brief    : Packs CHANNELS byte-serial samples into one framed pixel beat.
//            Optional macro PACKER_STALL_STATS_EN builds the STALL_CNT counter.
// Revision : 1.0 - initial release
// ============================================================================
module avl_stream_pixel_packer
    import avl_pixel_packer_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int CHANNELS    = 3,
    parameter int LEN_W       = 20,
    parameter int DEFAULT_LEN = 307200,
    parameter int ADDR_W      = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ADDR_W-1:0]          s_ctrl_address,
    input  logic                       s_ctrl_write,
    input  logic [31:0]                s_ctrl_writedata,
    input  logic                       s_ctrl_read,
    output logic [31:0]                s_ctrl_readdata,
    output logic                       s_ctrl_readdatavalid,
    input  logic [DATA_W-1:0]          snk_data,
    input  logic                       snk_valid,
    output logic                       snk_ready,
    output logic [CHANNELS*DATA_W-1:0] src_data,
    output logic                       src_valid,
    input  logic                       src_ready,
    output logic                       src_sop,
    output logic                       src_eop,
    output logic                       frame_done_irq
);

    localparam int c_ch_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [c_ch_w-1:0] c_last_ch = c_ch_w'(CHANNELS - 1);

    logic                              w_enable;
    logic                              w_soft_clear;
    logic [LEN_W-1:0]                  w_frame_len;
    logic [31:0]                       w_stall_cnt;
    status_word_t                      w_status;

    logic [c_ch_w-1:0]                 r_ch_cnt;
    logic [CHANNELS-1:0][DATA_W-1:0]   r_acc;
    logic [CHANNELS-1:0][DATA_W-1:0]   w_pixel;
    logic [CHANNELS*DATA_W-1:0]        r_src_data;
    logic                              r_src_valid;
    logic                              r_sop;
    logic                              r_eop;
    logic [LEN_W-1:0]                  r_pix_cnt;
    logic [LEN_W-1:0]                  r_len_shadow;
    logic [15:0]                       r_frames_done;

    logic                              w_last;
    logic                              w_snk_ready;
    logic                              w_accept;
    logic                              w_load;
    logic                              w_frame_end;
    logic                              w_frame_start;
    logic [LEN_W-1:0]                  w_len_eff;
    logic                              w_pix_last;

    pixel_packer_regs #(
        .LEN_W       (LEN_W),
        .DEFAULT_LEN (DEFAULT_LEN),
        .ADDR_W      (ADDR_W)
    ) u_regs (
        .clk             (clk),
        .reset           (reset),
        .i_address       (s_ctrl_address),
        .i_write         (s_ctrl_write),
        .i_writedata     (s_ctrl_writedata),
        .i_read          (s_ctrl_read),
        .o_readdata      (s_ctrl_readdata),
        .o_readdatavalid (s_ctrl_readdatavalid),
        .i_status        (w_status),
        .i_stall_cnt     (w_stall_cnt),
        .o_enable        (w_enable),
        .o_soft_clear    (w_soft_clear),
        .o_frame_len     (w_frame_len)
    );

    // Only the final sample of a pixel waits on a blocked output register
    assign w_last      = (r_ch_cnt == c_last_ch);
    assign w_snk_ready = w_enable && !w_soft_clear && !(w_last && r_src_valid && !src_ready);
    assign w_accept    = snk_valid && w_snk_ready;
    assign w_load      = w_accept && w_last;
    assign w_frame_end = r_src_valid && src_ready && r_eop;

    // A new frame uses the live FRAME_LEN; later pixels use the latched copy
    assign w_frame_start = (r_pix_cnt == '0);
    assign w_len_eff     = w_frame_start ? w_frame_len : r_len_shadow;
    assign w_pix_last    = (r_pix_cnt == (w_len_eff - LEN_W'(1)));

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_pixel
            assign w_pixel[i] = (r_ch_cnt == c_ch_w'(i)) ? snk_data : r_acc[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || w_soft_clear) begin
            r_acc <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_ch_cnt == c_ch_w'(i)) begin
                    r_acc[i] <= snk_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch_cnt      <= '0;
            r_src_data    <= '0;
            r_src_valid   <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_pix_cnt     <= '0;
            r_len_shadow  <= LEN_W'(DEFAULT_LEN);
            r_frames_done <= '0;
        end else if (w_soft_clear) begin
            r_ch_cnt      <= '0;
            r_src_data    <= '0;
            r_src_valid   <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_pix_cnt     <= '0;
            r_frames_done <= '0;
        end else begin
            if (w_accept) begin
                r_ch_cnt <= w_last ? '0 : r_ch_cnt + 1'b1;
            end
            if (w_load) begin
                r_src_data <= w_pixel;
                r_sop      <= w_frame_start;
                r_eop      <= w_pix_last;
                r_pix_cnt  <= w_pix_last ? '0 : r_pix_cnt + 1'b1;
                if (w_frame_start) begin
                    r_len_shadow <= w_frame_len;
                end
            end
            if (w_load) begin
                r_src_valid <= 1'b1;
            end else if (src_ready) begin
                r_src_valid <= 1'b0;
            end
            if (w_frame_end) begin
                r_frames_done <= r_frames_done + 1'b1;
            end
        end
    end

`ifdef PACKER_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_soft_clear) begin
            r_stall_cnt <= '0;
        end else if (r_src_valid && !src_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign w_stall_cnt = r_stall_cnt;
`else
    assign w_stall_cnt = '0;
`endif

    always_comb begin
        w_status             = '0;
        w_status.frames_done = r_frames_done;
        w_status.in_frame    = (r_pix_cnt != '0) || (r_ch_cnt != '0);
        w_status.src_valid   = r_src_valid;
    end

    assign snk_ready      = w_snk_ready;
    assign src_data       = r_src_data;
    assign src_valid      = r_src_valid;
    assign src_sop        = r_sop;
    assign src_eop        = r_eop;
    assign frame_done_irq = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_avl_stream_pixel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_avl_stream_pixel_packer
// Brief    : Self-checking bench for avl_stream_pixel_packer against a
//            queue-based stream/framing reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avl_stream_pixel_packer;

    localparam int DATA_W      = 8;
    localparam int CHANNELS    = 3;
    localparam int LEN_W       = 20;
    localparam int DEFAULT_LEN = 307200;
    localparam int ADDR_W      = 2;
    localparam int PW          = CHANNELS * DATA_W;
`ifdef PACKER_STALL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] s_ctrl_address = '0;
    logic              s_ctrl_write = 1'b0;
    logic [31:0]       s_ctrl_writedata = '0;
    logic              s_ctrl_read = 1'b0;
    logic [31:0]       s_ctrl_readdata;
    logic              s_ctrl_readdatavalid;
    logic [DATA_W-1:0] snk_data = '0;
    logic              snk_valid = 1'b0;
    logic              snk_ready;
    logic [PW-1:0]     src_data;
    logic              src_valid;
    logic              src_ready = 1'b0;
    logic              src_sop;
    logic              src_eop;
    logic              frame_done_irq;

    always #5 clk = ~clk;

    avl_stream_pixel_packer dut (
        .clk                  (clk),
        .reset                (reset),
        .s_ctrl_address       (s_ctrl_address),
        .s_ctrl_write         (s_ctrl_write),
        .s_ctrl_writedata     (s_ctrl_writedata),
        .s_ctrl_read          (s_ctrl_read),
        .s_ctrl_readdata      (s_ctrl_readdata),
        .s_ctrl_readdatavalid (s_ctrl_readdatavalid),
        .snk_data             (snk_data),
        .snk_valid            (snk_valid),
        .snk_ready            (snk_ready),
        .src_data             (src_data),
        .src_valid            (src_valid),
        .src_ready            (src_ready),
        .src_sop              (src_sop),
        .src_eop              (src_eop),
        .frame_done_irq       (frame_done_irq)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples of the incomplete pixel, formed pixels awaiting drain
    typedef struct packed {
        logic [PW-1:0] data;
        logic          sop;
        logic          eop;
    } pix_t;

    logic [DATA_W-1:0] q_in[$];
    pix_t              exp_q[$];
    logic [DATA_W-1:0] tx_q[$];
    int                m_pix = 0;
    int                m_cur_len = DEFAULT_LEN;
    int                m_len_reg = DEFAULT_LEN;
    bit                m_en = 1'b0;
    int                m_frames = 0;
    int                m_stall = 0;
    int                irq_cnt = 0;
    logic [PW-1:0]     last_pix = '0;
    bit                acc_flag = 1'b0;
    int                ready_mode = 0;
    bit                ready_force = 1'b0;
    bit                gaps = 1'b0;

    bit   mon_pend, mon_sc, mon_rdy, mon_hs, mon_irq;
    pix_t mon_p;

    always @(negedge clk) begin
        if (reset) begin
            q_in.delete();
            exp_q.delete();
            m_pix = 0;
            m_en = 1'b0;
            m_len_reg = DEFAULT_LEN;
            m_frames = 0;
            m_stall = 0;
            acc_flag = 1'b0;
        end else begin
            mon_pend = (exp_q.size() > 0);
            mon_sc   = s_ctrl_write && (s_ctrl_address == 2'd0) && s_ctrl_writedata[1];
            mon_rdy  = m_en && !mon_sc && !((q_in.size() == CHANNELS - 1) && mon_pend && !src_ready);
            mon_hs   = mon_pend && src_ready;
            mon_irq  = mon_hs ? exp_q[0].eop : 1'b0;
            chk("src_valid", src_valid, mon_pend);
            chk("snk_ready", snk_ready, mon_rdy);
            chk("irq", frame_done_irq, mon_irq);
            if (frame_done_irq) irq_cnt++;
            if (mon_hs) begin
                mon_p = exp_q.pop_front();
                last_pix = src_data;
                chk("src_data", src_data, mon_p.data);
                chk("src_sop", src_sop, mon_p.sop);
                chk("src_eop", src_eop, mon_p.eop);
                if (mon_p.eop) m_frames++;
            end
            if (mon_pend && !src_ready) m_stall++;
            acc_flag = snk_valid && snk_ready;
            if (acc_flag) begin
                q_in.push_back(snk_data);
                if (q_in.size() == CHANNELS) begin
                    mon_p.data = '0;
                    for (int k = 0; k < CHANNELS; k++) mon_p.data[k*DATA_W +: DATA_W] = q_in[k];
                    q_in.delete();
                    if (m_pix == 0) m_cur_len = m_len_reg;
                    mon_p.sop = (m_pix == 0);
                    mon_p.eop = (m_pix == m_cur_len - 1);
                    m_pix = mon_p.eop ? 0 : m_pix + 1;
                    exp_q.push_back(mon_p);
                end
            end
            if (s_ctrl_write && s_ctrl_address == 2'd0) begin
                m_en = s_ctrl_writedata[0];
                if (s_ctrl_writedata[1]) begin
                    q_in.delete();
                    exp_q.delete();
                    m_pix = 0;
                    m_frames = 0;
                    m_stall = 0;
                end
            end
            if (s_ctrl_write && s_ctrl_address == 2'd1) begin
                m_len_reg = (s_ctrl_writedata[LEN_W-1:0] == '0) ? 1 : int'(s_ctrl_writedata[LEN_W-1:0]);
            end
        end
    end

    // Stream source / sink driver, updates 2 time units after the edge
    always @(posedge clk) begin
        #2;
        if (reset) begin
            snk_valid = 1'b0;
        end else begin
            if (snk_valid && acc_flag) begin
                void'(tx_q.pop_front());
                snk_valid = 1'b0;
            end
            if (!snk_valid && tx_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                snk_valid = 1'b1;
                snk_data  = tx_q[0];
            end
        end
        src_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(1)) : ready_force;
    end

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        s_ctrl_write = 1'b1; s_ctrl_address = addr; s_ctrl_writedata = data;
        @(posedge clk); #1;
        s_ctrl_write = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        s_ctrl_read = 1'b1; s_ctrl_address = addr;
        chk({tag, "_rdv_early"}, s_ctrl_readdatavalid, 1'b0);
        @(posedge clk); #1;
        s_ctrl_read = 1'b0;
        chk({tag, "_rdv"}, s_ctrl_readdatavalid, 1'b1);
        chk(tag, s_ctrl_readdata, exp);
    endtask

    task automatic push_seq(input int n, input int first);
        for (int i = 0; i < n; i++) tx_q.push_back(DATA_W'(first + i));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            ok = (tx_q.size() == 0) && !snk_valid && (exp_q.size() == 0);
        end
        chk({tag, "_timeout"}, ok, 1'b1);
    endtask

    task automatic wait_tx(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            ok = (tx_q.size() == 0) && !snk_valid;
        end
        chk({tag, "_timeout"}, ok, 1'b1);
    endtask

    function automatic logic [31:0] status_exp();
        return {16'(m_frames), 14'd0, (m_pix != 0 || q_in.size() != 0), 1'b0};
    endfunction

    initial begin
        int irq0;
        int len;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_src_valid", src_valid, 1'b0);
        chk("rst_src_sop", src_sop, 1'b0);
        chk("rst_src_eop", src_eop, 1'b0);
        chk("rst_src_data", src_data, '0);
        chk("rst_snk_ready", snk_ready, 1'b0);
        chk("rst_irq", frame_done_irq, 1'b0);
        chk("rst_rdv", s_ctrl_readdatavalid, 1'b0);
        chk("rst_readdata", s_ctrl_readdata, '0);
        reset = 1'b0;
        reg_read("len_default", 2'd1, 32'(DEFAULT_LEN));
        reg_read("ctrl_default", 2'd0, 32'd0);
        reg_read("status_default", 2'd2, 32'd0);
        reg_read("stall_default", 2'd3, 32'd0);

        // Basic packing, two frames of two pixels
        gaps = 1'b0; ready_mode = 0;
        reg_write(2'd1, 32'd2);
        reg_write(2'd0, 32'd1);
        irq0 = irq_cnt;
        push_seq(12, 1);
        wait_idle("basic", 200);
        chk("basic_last_pixel", last_pix, 24'h0C0B0A);
        chk("basic_irq_count", irq_cnt - irq0, 2);
        reg_read("basic_status", 2'd2, {16'd2, 16'd0});

        // Output stall for five cycles
        reg_write(2'd0, 32'd3);
        gaps = 1'b1; ready_force = 1'b0; ready_mode = 2;
        push_seq(6, 8'h10);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            seen = src_valid;
        end
        chk("stall_pixel_seen", seen, 1'b1);
        repeat (5) @(posedge clk);
        #1 ready_force = 1'b1;
        wait_idle("stall", 200);
        reg_read("stall_cnt", 2'd3, STATS ? 32'd5 : 32'd0);
        ready_mode = 0;

        // FRAME_LEN change mid-frame
        irq0 = irq_cnt;
        reg_write(2'd1, 32'd4);
        push_seq(3, 8'h20);
        wait_idle("len4", 200);
        reg_write(2'd1, 32'd1);
        push_seq(15, 8'h30);
        wait_idle("len1", 300);
        chk("lenchg_irq_count", irq_cnt - irq0, 3);

        // Enable dropped with two samples of a pixel held
        push_seq(2, 8'h40);
        wait_tx("en_pre", 200);
        reg_write(2'd0, 32'd0);
        push_seq(1, 8'h42);
        repeat (10) @(posedge clk);
        reg_write(2'd0, 32'd1);
        wait_idle("en_resume", 200);
        chk("en_resume_pixel", last_pix, 24'h424140);

        // soft_clear with a pending pixel and one sample accumulated
        reg_write(2'd1, 32'd3);
        ready_force = 1'b0; ready_mode = 2;
        push_seq(4, 8'h50);
        wait_tx("sc_pre", 200);
        reg_write(2'd0, 32'd3);
        reg_read("sc_status", 2'd2, 32'd0);
        ready_mode = 0;
        push_seq(3, 8'h60);
        wait_idle("sc_post", 200);

        // Randomised traffic under random backpressure and frame lengths
        for (int r = 0; r < 4; r++) begin
            len = $urandom_range(1, 5);
            reg_write(2'd1, 32'(len));
            ready_mode = 1; gaps = 1'b1;
            for (int i = 0; i < CHANNELS * $urandom_range(2, 10); i++) tx_q.push_back(DATA_W'($urandom));
            wait_idle("rand", 2000);
            ready_mode = 0;
            reg_read("rand_stall", 2'd3, STATS ? 32'(m_stall) : 32'd0);
            reg_read("rand_status", 2'd2, status_exp());
        end

        reg_write(2'd1, 32'd0);
        reg_read("len_zero", 2'd1, 32'd1);

        // Synchronous reset in the middle of a pixel
        push_seq(2, 8'h70);
        wait_tx("rst_pre", 200);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_src_valid", src_valid, 1'b0);
        chk("mid_rst_sop", src_sop, 1'b0);
        chk("mid_rst_eop", src_eop, 1'b0);
        chk("mid_rst_data", src_data, '0);
        chk("mid_rst_snk_ready", snk_ready, 1'b0);
        chk("mid_rst_readdata", s_ctrl_readdata, '0);
        reset = 1'b0;
        reg_read("mid_rst_len", 2'd1, 32'(DEFAULT_LEN));
        reg_read("mid_rst_ctrl", 2'd0, 32'd0);
        reg_read("mid_rst_status", 2'd2, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
